// File: rtl/fcl1_pkg.sv
// Shared types and sizing helpers for the first fully-connected layer controller.
package fcl1_pkg;

    localparam int N_IN_DEF    = 400;
    localparam int N_OUT_DEF   = 120;
    localparam int RD_LAT_DEF  = 1;
    localparam int MAC_LAT_DEF = 2;

    // Address width for a range of n entries; a single entry still needs one bit.
    function automatic int cw(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int IN_AW_DEF  = cw(N_IN_DEF);
    localparam int W_AW_DEF   = cw(N_IN_DEF * N_OUT_DEF);
    localparam int OUT_AW_DEF = cw(N_OUT_DEF);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        ACCUM,
        DRAIN,
        WRITE,
        DONE
    } state_t;

endpackage

// File: rtl/fcl1_ctrl_cnt.sv
// Parametric up-counter with synchronous clear, enable and terminal-count flag.
module fcl1_ctrl_cnt #(
    parameter int W   = 4,
    parameter int MAX = 15
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] cnt,
    output logic         tc
);

    assign tc = (cnt == W'(MAX));

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tc ? '0 : cnt + W'(1);
        end
    end

endmodule

// File: rtl/fcl1_ctrl.sv
// Sequencer for one fully-connected layer: walks every neuron, streams its weights
// and inputs to the MAC, waits out the pipeline and hands each result to the sink.
module fcl1_ctrl
    import fcl1_pkg::*;
#(
    parameter int N_IN    = N_IN_DEF,
    parameter int N_OUT   = N_OUT_DEF,
    parameter int RD_LAT  = RD_LAT_DEF,
    parameter int MAC_LAT = MAC_LAT_DEF
) (
    input  logic                         fcl1_ctrl_clk,
    input  logic                         fcl1_ctrl_rst,
    input  logic                         fcl1_ctrl_start_i,
    input  logic                         fcl1_ctrl_abort_i,
    input  logic                         fcl1_ctrl_out_ready_i,
    output logic                         fcl1_ctrl_rd_en_o,
    output logic [cw(N_IN)-1:0]          fcl1_ctrl_in_addr_o,
    output logic [cw(N_IN*N_OUT)-1:0]    fcl1_ctrl_w_addr_o,
    output logic                         fcl1_ctrl_acc_clr_o,
    output logic                         fcl1_ctrl_mac_en_o,
    output logic                         fcl1_ctrl_out_valid_o,
    output logic [cw(N_OUT)-1:0]         fcl1_ctrl_out_addr_o,
    output logic                         fcl1_ctrl_busy_o,
    output logic                         fcl1_ctrl_done_o
);

    localparam int IN_AW     = cw(N_IN);
    localparam int W_AW      = cw(N_IN * N_OUT);
    localparam int OUT_AW    = cw(N_OUT);
    localparam int DRAIN_LEN = RD_LAT + MAC_LAT;
    localparam int D_W       = cw(DRAIN_LEN);

    state_t          state;
    logic [W_AW-1:0] base;
    logic [D_W-1:0]  dcnt;
    logic            i_en, i_clr, i_tc;
    logic            n_en, n_clr, n_tc;

    // The input index doubles as the input address; it stops at N_IN-1 so the
    // address holds its last value once the neuron has been streamed.
    assign i_clr = !fcl1_ctrl_abort_i && (state == CLEAR);
    assign i_en  = !fcl1_ctrl_abort_i && (state == ACCUM) && !i_tc;
    assign n_clr = !fcl1_ctrl_abort_i && (state == IDLE) && fcl1_ctrl_start_i;
    assign n_en  = !fcl1_ctrl_abort_i && (state == WRITE) && fcl1_ctrl_out_ready_i && !n_tc;

    fcl1_ctrl_cnt #(.W(IN_AW), .MAX(N_IN - 1)) u_in_cnt (
        .clk (fcl1_ctrl_clk),
        .rst (fcl1_ctrl_rst),
        .en  (i_en),
        .clr (i_clr),
        .cnt (fcl1_ctrl_in_addr_o),
        .tc  (i_tc)
    );

    fcl1_ctrl_cnt #(.W(OUT_AW), .MAX(N_OUT - 1)) u_out_cnt (
        .clk (fcl1_ctrl_clk),
        .rst (fcl1_ctrl_rst),
        .en  (n_en),
        .clr (n_clr),
        .cnt (fcl1_ctrl_out_addr_o),
        .tc  (n_tc)
    );

    always_ff @(posedge fcl1_ctrl_clk or posedge fcl1_ctrl_rst) begin
        if (fcl1_ctrl_rst) begin
            state                 <= IDLE;
            fcl1_ctrl_rd_en_o     <= 1'b0;
            fcl1_ctrl_acc_clr_o   <= 1'b0;
            fcl1_ctrl_out_valid_o <= 1'b0;
            fcl1_ctrl_busy_o      <= 1'b0;
            fcl1_ctrl_done_o      <= 1'b0;
            fcl1_ctrl_w_addr_o    <= '0;
            base                  <= '0;
            dcnt                  <= '0;
        end else if (fcl1_ctrl_abort_i) begin
            state                 <= IDLE;
            fcl1_ctrl_rd_en_o     <= 1'b0;
            fcl1_ctrl_acc_clr_o   <= 1'b0;
            fcl1_ctrl_out_valid_o <= 1'b0;
            fcl1_ctrl_busy_o      <= 1'b0;
            fcl1_ctrl_done_o      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (fcl1_ctrl_start_i) begin
                        state               <= CLEAR;
                        fcl1_ctrl_acc_clr_o <= 1'b1;
                        fcl1_ctrl_busy_o    <= 1'b1;
                        base                <= '0;
                    end
                end
                CLEAR: begin
                    state               <= ACCUM;
                    fcl1_ctrl_acc_clr_o <= 1'b0;
                    fcl1_ctrl_rd_en_o   <= 1'b1;
                    fcl1_ctrl_w_addr_o  <= base;
                end
                ACCUM: begin
                    if (i_tc) begin
                        state             <= DRAIN;
                        fcl1_ctrl_rd_en_o <= 1'b0;
                        dcnt              <= D_W'(DRAIN_LEN - 1);
                    end else begin
                        fcl1_ctrl_w_addr_o <= fcl1_ctrl_w_addr_o + W_AW'(1);
                    end
                end
                DRAIN: begin
                    if (dcnt == '0) begin
                        state                 <= WRITE;
                        fcl1_ctrl_out_valid_o <= 1'b1;
                    end else begin
                        dcnt <= dcnt - D_W'(1);
                    end
                end
                WRITE: begin
                    if (fcl1_ctrl_out_ready_i) begin
                        fcl1_ctrl_out_valid_o <= 1'b0;
                        if (n_tc) begin
                            state            <= DONE;
                            fcl1_ctrl_done_o <= 1'b1;
                        end else begin
                            state               <= CLEAR;
                            fcl1_ctrl_acc_clr_o <= 1'b1;
                            // Weight rows are contiguous, so the next neuron starts N_IN further on.
                            base                <= base + W_AW'(N_IN);
                        end
                    end
                end
                DONE: begin
                    state            <= IDLE;
                    fcl1_ctrl_done_o <= 1'b0;
                    fcl1_ctrl_busy_o <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // mac_en follows the read strobe by exactly the memory read latency.
    generate
        if (RD_LAT == 0) begin : g_no_dly
            assign fcl1_ctrl_mac_en_o = fcl1_ctrl_rd_en_o;
        end else begin : g_dly
            logic [RD_LAT-1:0] dly;
            always_ff @(posedge fcl1_ctrl_clk or posedge fcl1_ctrl_rst) begin
                if (fcl1_ctrl_rst) begin
                    dly <= '0;
                end else if (fcl1_ctrl_abort_i) begin
                    dly <= '0;
                end else begin
                    dly <= (dly << 1) | RD_LAT'(fcl1_ctrl_rd_en_o);
                end
            end
            assign fcl1_ctrl_mac_en_o = dly[RD_LAT-1];
        end
    endgenerate

endmodule

// File: doc/fcl1_ctrl.md
FCL1_CTRL -- requirements
Module: fcl1_ctrl

Interface
REQ-001 SHALL have parameters: N_IN, default 400, inputs per neuron.
REQ-002 SHALL have parameters: N_OUT, default 120, neurons in layer.
REQ-003 SHALL have parameters: RD_LAT, default 1, weight/input memory read latency in cycles.
REQ-004 SHALL have parameters: MAC_LAT, default 2, MAC pipeline depth in cycles.
REQ-005 SHALL have ports: fcl1_ctrl_clk  in  1  single clock; all state on rising edge.
REQ-006 SHALL have ports: fcl1_ctrl_rst  in  1  reset, asynchronous, active-high.
REQ-007 SHALL have ports: fcl1_ctrl_start_i  in  1  start-layer request.
REQ-008 SHALL have ports: fcl1_ctrl_abort_i  in  1  synchronous abort.
REQ-009 SHALL have ports: fcl1_ctrl_out_ready_i  in  1  result sink ready.
REQ-010 SHALL have ports: fcl1_ctrl_rd_en_o  out  1  memory read strobe.
REQ-011 SHALL have ports: fcl1_ctrl_in_addr_o  out  clog2(N_IN)  input-vector address.
REQ-012 SHALL have ports: fcl1_ctrl_w_addr_o  out  clog2(N_IN*N_OUT)  weight address.
REQ-013 SHALL have ports: fcl1_ctrl_acc_clr_o  out  1  accumulator clear.
REQ-014 SHALL have ports: fcl1_ctrl_mac_en_o  out  1  MAC accumulate enable.
REQ-015 SHALL have ports: fcl1_ctrl_out_valid_o  out  1  neuron result valid.
REQ-016 SHALL have ports: fcl1_ctrl_out_addr_o  out  clog2(N_OUT)  neuron index of result.
REQ-017 SHALL have ports: fcl1_ctrl_busy_o  out  1  layer in progress; fcl1_ctrl_done_o  out  1  layer-complete pulse.

Function
REQ-018 SHALL implement FSM states IDLE, CLEAR, ACCUM, DRAIN, WRITE, DONE.
REQ-019 IDLE: busy_o=0; start_i=1 -> CLEAR, neuron index n=0; start_i in any other state SHALL be ignored.
REQ-020 CLEAR: acc_clr_o=1 for exactly one cycle, input index i=0 -> ACCUM.
REQ-021 ACCUM: rd_en_o=1 every cycle, in_addr_o=i, w_addr_o=n*N_IN+i; i increments; after i=N_IN-1 -> DRAIN (N_IN cycles total).
REQ-022 mac_en_o SHALL equal rd_en_o delayed by exactly RD_LAT cycles (shift register, cleared on reset/abort).
REQ-023 DRAIN: SHALL last RD_LAT+MAC_LAT cycles, then -> WRITE.
REQ-024 WRITE: out_valid_o=1, out_addr_o=n, held stable until out_valid_o&out_ready_i; on handshake: n=N_OUT-1 -> DONE, else n+1 -> CLEAR.
REQ-025 DONE: done_o=1 for exactly one cycle -> IDLE; done_o=0 in all other states.
REQ-026 busy_o SHALL be 1 in every state except IDLE.
REQ-027 w_addr_o SHALL be generated by a running base register (+N_IN per neuron), no multiplier.
REQ-028 abort_i=1 SHALL force IDLE next edge from any state, clear delay line, no done_o; abort has priority over start_i.
REQ-029 Outside ACCUM, rd_en_o=0 and addresses hold last value.
REQ-030 With out_ready_i held 1, start-sampled to done_o SHALL be N_OUT*(N_IN+RD_LAT+MAC_LAT+2)+1 cycles.

Reset
REQ-031 On rst: state IDLE, n=0, i=0, delay line 0, all outputs 0 (addresses 0).
REQ-032 Reset asserted mid-layer SHALL abandon the layer; first start_i after release SHALL begin at neuron 0.

Structure
REQ-033 FSM state enum and clog2-derived width localparams SHALL live in shared package fcl1_pkg.
REQ-034 SHALL instantiate sub-module fcl1_ctrl_cnt (parametric up-counter: en, clr, terminal-count flag) for i and n.

Verification (N_IN=4, N_OUT=3, RD_LAT=1, MAC_LAT=2)
REQ-035 start_i one-cycle pulse, out_ready_i=1 -> three out_valid_o beats out_addr 0,1,2; done_o pulse 28 cycles after start sampled; busy_o high throughout.
REQ-036 Neuron 1 ACCUM -> w_addr_o 4,5,6,7 with in_addr_o 0,1,2,3; mac_en_o mirrors rd_en_o one cycle late; acc_clr_o one cycle before first rd_en_o.
REQ-037 out_ready_i=0 for 5 cycles in WRITE of neuron 0 -> out_valid_o/out_addr_o=0 stable 5 cycles, no rd_en_o; done_o at cycle 33.
REQ-038 start_i re-pulsed during ACCUM -> ignored, done_o still at cycle 28, single done_o.
REQ-039 abort_i in DRAIN of neuron 1 -> IDLE next cycle, busy_o=0, no done_o, mac_en_o=0; new start -> restarts at out_addr 0.
REQ-040 rst asserted mid-ACCUM -> all outputs 0 immediately (asynchronous), state IDLE after release.
